dma_desc_queue: RTL and testbench

Upstream command front-end for simple_dma_controller. The CPU writes transfer descriptors (src, dst, length) through a small memory-mapped register window. Descriptors are buffered in a FIFO and issued one at a time to the DMA controller over its start/busy/done handshake. The block also provides status, a completion counter and a sticky interrupt.

---
 rtl/dma_desc_pkg.sv | 40 ++++
 rtl/desc_fifo.sv | 67 ++++++
 rtl/dma_desc_queue.sv | 179 +++++++++++++++++
 tb/tb_dma_desc_queue.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_desc_pkg.sv
// Shared types and register map for the DMA descriptor queue.
// desc_t field widths match the default top-level ADDR_W/LEN_W.
package dma_desc_pkg;

    localparam int DESC_ADDR_W = 32;
    localparam int DESC_LEN_W  = 16;

    typedef struct packed {
        logic [DESC_ADDR_W-1:0] src;
        logic [DESC_ADDR_W-1:0] dst;
        logic [DESC_LEN_W-1:0]  len;
    } desc_t;

    localparam logic [4:0] REG_SRC    = 5'h00;
    localparam logic [4:0] REG_DST    = 5'h04;
    localparam logic [4:0] REG_LEN    = 5'h08;
    localparam logic [4:0] REG_CTRL   = 5'h0C;
    localparam logic [4:0] REG_IRQ_EN = 5'h10;

    localparam int CTRL_PUSH    = 0;
    localparam int CTRL_FLUSH   = 1;
    localparam int CTRL_CLR_IRQ = 2;
    localparam int CTRL_CLR_ERR = 3;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_ACTIVE    = 2;
    localparam int ST_IRQ       = 3;
    localparam int ST_ERR_ZERO  = 4;
    localparam int ST_ERR_OVF   = 5;
    localparam int ST_COUNT_LSB = 8;
    localparam int ST_DONE_LSB  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/desc_fifo.sv
// First-word-fall-through descriptor FIFO; pointers carry an extra wrap bit
// so full and empty are distinguishable without a separate counter.
module desc_fifo
    import dma_desc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    flush,
    input  desc_t                   din,
    output desc_t                   dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);

    desc_t       mem [DEPTH];
    logic [AW:0] wr_ptr_reg, wr_ptr_next;
    logic [AW:0] rd_ptr_reg, rd_ptr_next;
    logic        push_ok;
    logic        pop_ok;

    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign count = wr_ptr_reg - rd_ptr_reg;
    assign dout  = mem[rd_ptr_reg[AW-1:0]];

    // Flush empties the queue first, so a simultaneous push always lands.
    assign push_ok = push && (flush || !full);
    assign pop_ok  = pop && !empty && !flush;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (flush) begin
            rd_ptr_next = wr_ptr_reg;
        end else if (pop_ok) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        if (push_ok) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/dma_desc_queue.sv
// CPU register window that queues DMA descriptors and issues them one at a
// time over the start/busy/done handshake, with status, counter and irq.
module dma_desc_queue
    import dma_desc_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = DESC_ADDR_W,
    parameter int LEN_W  = DESC_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_wr,
    input  logic              reg_rd,
    input  logic [4:0]        reg_addr,
    input  logic [31:0]       reg_wdata,
    output logic [31:0]       reg_rdata,
    output logic              dma_start,
    output logic [ADDR_W-1:0] dma_src_addr,
    output logic [ADDR_W-1:0] dma_dst_addr,
    output logic [LEN_W-1:0]  dma_len,
    input  logic              dma_busy,
    input  logic              dma_done,
    output logic              irq
);

    logic [31:0]       src_reg, dst_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [ADDR_W-1:0] dma_src_reg, dma_dst_reg;
    logic [LEN_W-1:0]  dma_len_reg;
    logic [31:0]       rdata_reg, rd_mux;
    logic [7:0]        done_cnt_reg;
    logic              irq_reg, irq_en_reg;
    logic              err_zero_reg, err_ovf_reg;
    state_t            state_reg, state_next;

    logic                   ctrl_wr, push_req, flush_req, clr_irq, clr_err;
    logic                   len_zero, fifo_push, fifo_pop, overflow, xfer_done;
    desc_t                  fifo_din, fifo_dout;
    logic                   fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;

    assign ctrl_wr   = reg_wr && (reg_addr == REG_CTRL);
    assign push_req  = ctrl_wr && reg_wdata[CTRL_PUSH];
    assign flush_req = ctrl_wr && reg_wdata[CTRL_FLUSH];
    assign clr_irq   = ctrl_wr && reg_wdata[CTRL_CLR_IRQ];
    assign clr_err   = ctrl_wr && reg_wdata[CTRL_CLR_ERR];

    assign len_zero  = (len_reg == '0);
    assign fifo_push = push_req && !len_zero;
    // fifo_full is the registered flag, so a pop in the same cycle does not make room.
    assign overflow  = fifo_push && fifo_full && !flush_req;
    assign xfer_done = (state_reg == WAIT) && dma_done;

    assign fifo_din.src = DESC_ADDR_W'(src_reg);
    assign fifo_din.dst = DESC_ADDR_W'(dst_reg);
    assign fifo_din.len = DESC_LEN_W'(len_reg);

    desc_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (flush_req),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_next = state_reg;
        fifo_pop   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty && !dma_busy) begin
                    fifo_pop   = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT: begin
                if (dma_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            dma_src_reg <= '0;
            dma_dst_reg <= '0;
            dma_len_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (fifo_pop) begin
                dma_src_reg <= ADDR_W'(fifo_dout.src);
                dma_dst_reg <= ADDR_W'(fifo_dout.dst);
                dma_len_reg <= LEN_W'(fifo_dout.len);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_reg    <= '0;
            dst_reg    <= '0;
            len_reg    <= '0;
            irq_en_reg <= 1'b0;
        end else if (reg_wr) begin
            case (reg_addr)
                REG_SRC:    src_reg    <= reg_wdata;
                REG_DST:    dst_reg    <= reg_wdata;
                REG_LEN:    len_reg    <= reg_wdata[LEN_W-1:0];
                REG_IRQ_EN: irq_en_reg <= reg_wdata[0];
                default: ;
            endcase
        end
    end

    // Sticky bits: a set in the same cycle as its clear takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt_reg <= '0;
            irq_reg      <= 1'b0;
            err_zero_reg <= 1'b0;
            err_ovf_reg  <= 1'b0;
        end else begin
            if (xfer_done) begin
                done_cnt_reg <= done_cnt_reg + 8'd1;
            end
            irq_reg      <= (irq_reg && !clr_irq) || (xfer_done && irq_en_reg);
            err_zero_reg <= (err_zero_reg && !clr_err) || (push_req && len_zero);
            err_ovf_reg  <= (err_ovf_reg && !clr_err) || overflow;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            REG_SRC: rd_mux = src_reg;
            REG_DST: rd_mux = dst_reg;
            REG_LEN: rd_mux = 32'(len_reg);
            REG_CTRL: begin
                rd_mux[ST_EMPTY]              = fifo_empty;
                rd_mux[ST_FULL]               = fifo_full;
                rd_mux[ST_ACTIVE]             = (state_reg != IDLE);
                rd_mux[ST_IRQ]                = irq_reg;
                rd_mux[ST_ERR_ZERO]           = err_zero_reg;
                rd_mux[ST_ERR_OVF]            = err_ovf_reg;
                rd_mux[ST_COUNT_LSB +: 8]     = 8'(fifo_count);
                rd_mux[ST_DONE_LSB +: 8]      = done_cnt_reg;
            end
            REG_IRQ_EN: rd_mux[0] = irq_en_reg;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_reg <= '0;
        end else if (reg_rd) begin
            rdata_reg <= rd_mux;
        end
    end

    assign reg_rdata    = rdata_reg;
    assign dma_start    = (state_reg == ISSUE);
    assign dma_src_addr = dma_src_reg;
    assign dma_dst_addr = dma_dst_reg;
    assign dma_len      = dma_len_reg;
    assign irq          = irq_reg;

endmodule

// File: tb/tb_dma_desc_queue.sv
// Directed + randomized bench for dma_desc_queue; a queue-based model of the
// descriptor FIFO and status bits predicts every observed value.
module tb_dma_desc_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] len;
    } tdesc_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reg_wr = 1'b0;
    logic        reg_rd = 1'b0;
    logic [4:0]  reg_addr = '0;
    logic [31:0] reg_wdata = '0;
    logic [31:0] reg_rdata;
    logic        dma_start;
    logic [31:0] dma_src_addr, dma_dst_addr;
    logic [15:0] dma_len;
    logic        dma_busy = 1'b0;
    logic        dma_done = 1'b0;
    logic        irq;

    dma_desc_queue #(.DEPTH(DEPTH), .ADDR_W(32), .LEN_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .reg_wr       (reg_wr),
        .reg_rd       (reg_rd),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_rdata    (reg_rdata),
        .dma_start    (dma_start),
        .dma_src_addr (dma_src_addr),
        .dma_dst_addr (dma_dst_addr),
        .dma_len      (dma_len),
        .dma_busy     (dma_busy),
        .dma_done     (dma_done),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int start_total = 0;
    int xfer_total = 0;

    tdesc_t     model_q[$];
    tdesc_t     obs_q[$];
    tdesc_t     stg = '{32'h0, 32'h0, 16'h0};
    tdesc_t     cur = '{32'h0, 32'h0, 16'h0};
    logic [7:0] m_done = '0;
    logic       m_irq = 1'b0, m_irq_en = 1'b0, m_ezero = 1'b0, m_eovf = 1'b0;

    // Records every start pulse; a pulse lasting two cycles shows up twice.
    always @(negedge clk) begin
        if (rst_n && dma_start) begin
            obs_q.push_back('{dma_src_addr, dma_dst_addr, dma_len});
            start_total++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reg_write(input logic [4:0] a, input logic [31:0] d);
        reg_addr  = a;
        reg_wdata = d;
        reg_wr    = 1'b1;
        tick();
        reg_wr    = 1'b0;
    endtask

    task automatic reg_read(input logic [4:0] a, output logic [31:0] d);
        reg_addr = a;
        reg_rd   = 1'b1;
        tick();
        reg_rd   = 1'b0;
        d        = reg_rdata;
    endtask

    function automatic logic [31:0] exp_status(input logic active);
        logic [31:0] s;
        s        = '0;
        s[0]     = (model_q.size() == 0);
        s[1]     = (model_q.size() == DEPTH);
        s[2]     = active;
        s[3]     = m_irq;
        s[4]     = m_ezero;
        s[5]     = m_eovf;
        s[15:8]  = 8'(model_q.size());
        s[23:16] = m_done;
        return s;
    endfunction

    task automatic check_status(input string tag, input logic active);
        logic [31:0] r;
        reg_read(5'h0C, r);
        check(tag, r, exp_status(active));
    endtask

    task automatic stage(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        reg_write(5'h00, s);
        reg_write(5'h04, d);
        reg_write(5'h08, {16'h0, l});
        stg = '{s, d, l};
    endtask

    task automatic ctrl(input logic [3:0] bits);
        reg_write(5'h0C, {28'h0, bits});
        if (bits[3]) begin m_ezero = 1'b0; m_eovf = 1'b0; end
        if (bits[2]) m_irq = 1'b0;
        if (bits[1]) model_q.delete();
        if (bits[0]) begin
            if (stg.len == 16'h0)            m_ezero = 1'b1;
            else if (model_q.size() == DEPTH) m_eovf = 1'b1;
            else                             model_q.push_back(stg);
        end
    endtask

    task automatic push_desc(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        stage(s, d, l);
        ctrl(4'b0001);
    endtask

    task automatic expect_start(input string tag);
        int n;
        tdesc_t o;
        n = 0;
        while (obs_q.size() == 0 && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_start_seen"}, 32'(obs_q.size() > 0), 32'd1);
        check({tag, "_model_pending"}, 32'(model_q.size() > 0), 32'd1);
        if (obs_q.size() > 0 && model_q.size() > 0) begin
            o   = obs_q.pop_front();
            cur = model_q.pop_front();
            check({tag, "_src"}, o.src, cur.src);
            check({tag, "_dst"}, o.dst, cur.dst);
            check({tag, "_len"}, 32'(o.len), 32'(cur.len));
            xfer_total++;
            $display("xfer %0d: src=%h dst=%h len=%h", xfer_total, o.src, o.dst, o.len);
        end
    endtask

    task automatic finish_xfer(input int delay);
        repeat (delay) tick();
        check("hold_src", dma_src_addr, cur.src);
        check("hold_len", 32'(dma_len), 32'(cur.len));
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        m_done++;
        if (m_irq_en) m_irq = 1'b1;
    endtask

    initial begin
        logic [31:0] r;
        int s0, n;
        logic [15:0] l;

        // Reset state
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_start", 32'(dma_start), 32'd0);
        check("reset_src", dma_src_addr, 32'd0);
        check("reset_rdata", reg_rdata, 32'd0);
        check_status("reset_status", 1'b0);

        // Single directed transfer
        push_desc(32'h1000, 32'h2000, 16'd16);
        s0 = start_total;
        expect_start("single");
        finish_xfer(5);
        repeat (3) tick();
        check("single_one_pulse", 32'(start_total - s0), 32'd1);
        check_status("single_status", 1'b0);

        // Overflow while the DMA is busy, then drain in order
        dma_busy = 1'b1;
        repeat (5) push_desc($urandom, $urandom, 16'($urandom_range(1, 65535)));
        check_status("ovf_status", 1'b0);
        s0 = start_total;
        dma_busy = 1'b0;
        repeat (4) begin
            expect_start("drain");
            finish_xfer($urandom_range(1, 6));
        end
        repeat (10) tick();
        check("drain_starts", 32'(start_total - s0), 32'd4);
        check_status("drain_status", 1'b0);

        // Flush and push in one write: the staged descriptor survives alone
        dma_busy = 1'b1;
        repeat (2) push_desc($urandom, $urandom, 16'($urandom_range(1, 65535)));
        stage($urandom, $urandom, 16'($urandom_range(1, 65535)));
        ctrl(4'b0011);
        check_status("flushpush_status", 1'b0);
        dma_busy = 1'b0;
        expect_start("flushpush");
        finish_xfer(2);

        // Zero length push, stray done in IDLE, error clear
        s0 = start_total;
        push_desc(32'hAAAA_0000, 32'hBBBB_0000, 16'd0);
        repeat (10) tick();
        check("zero_no_start", 32'(start_total - s0), 32'd0);
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        check_status("zero_err_status", 1'b0);
        ctrl(4'b1000);
        check_status("err_clear_status", 1'b0);

        // Interrupt enable, set and clear
        reg_write(5'h10, 32'hFFFF_FFFF);
        m_irq_en = 1'b1;
        reg_read(5'h10, r);
        check("irq_en_read", r, 32'd1);
        reg_write(5'h14, 32'h1234_5678);
        reg_read(5'h14, r);
        check("unmapped_read", r, 32'd0);
        push_desc($urandom, $urandom, 16'($urandom_range(1, 65535)));
        expect_start("irq");
        finish_xfer(3);
        check("irq_set", 32'(irq), 32'(m_irq));
        ctrl(4'b0100);
        check("irq_cleared", 32'(irq), 32'd0);

        // Flush with one transfer in flight and two queued
        push_desc($urandom, $urandom, 16'($urandom_range(1, 65535)));
        expect_start("inflight");
        repeat (2) push_desc($urandom, $urandom, 16'($urandom_range(1, 65535)));
        check_status("queued_status", 1'b1);
        ctrl(4'b0010);
        check_status("flushed_status", 1'b1);
        s0 = start_total;
        finish_xfer(2);
        repeat (10) tick();
        check("flush_no_start", 32'(start_total - s0), 32'd0);
        check("flush_irq", 32'(irq), 32'd1);
        check_status("flush_done_status", 1'b0);

        // Random batches until the done counter has wrapped
        while (xfer_total < 270) begin
            dma_busy = 1'b1;
            n = $urandom_range(1, DEPTH + 1);
            for (int i = 0; i < n; i++) begin
                l = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(1, 65535));
                push_desc($urandom, $urandom, l);
            end
            check_status("rnd_queued", 1'b0);
            dma_busy = 1'b0;
            while (model_q.size() > 0) begin
                expect_start("rnd");
                finish_xfer($urandom_range(0, 4));
            end
            check_status("rnd_drained", 1'b0);
            if (m_ezero || m_eovf) ctrl(4'b1000);
        end

        // Asynchronous reset in the middle of a transfer
        reg_read(5'h0C, r);
        push_desc(32'hDEAD_BEEF, 32'hCAFE_F00D, 16'h0040);
        expect_start("rst");
        tick();
        rst_n = 1'b0;
        #2;
        check("rst_start", 32'(dma_start), 32'd0);
        check("rst_src", dma_src_addr, 32'd0);
        check("rst_dst", dma_dst_addr, 32'd0);
        check("rst_len", 32'(dma_len), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_rdata", reg_rdata, 32'd0);
        #1;
        rst_n = 1'b1;
        model_q.delete();
        obs_q.delete();
        m_done = '0; m_irq = 1'b0; m_irq_en = 1'b0; m_ezero = 1'b0; m_eovf = 1'b0;
        tick();
        check_status("post_rst_status", 1'b0);
        reg_read(5'h10, r);
        check("post_rst_irq_en", r, 32'd0);
        reg_read(5'h00, r);
        check("post_rst_src_stage", r, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
